// File: rtl/dps_uart_pkg.sv
// Shared types and constants for the dps_uart receive path.
package dps_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rxState_e;

    localparam int OSR       = 16;
    localparam int DATA_BITS = 8;

    localparam logic [3:0] SAMP_A    = 4'd7;
    localparam logic [3:0] SAMP_B    = 4'd8;
    localparam logic [3:0] SAMP_C    = 4'd9;
    localparam logic [3:0] SAMP_LAST = 4'd15;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/dps_uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every iDIV+1 clocks, restartable.
module dps_uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             iCLOCK,
    input  logic             inRESET,
    input  logic [DIV_W-1:0] iDIV,
    input  logic             iRESTART,
    output logic             oTICK
);

    logic [DIV_W-1:0] divCnt;

    assign oTICK = (divCnt == iDIV);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            divCnt <= '0;
        end else if (iRESTART || oTICK) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

endmodule

// File: rtl/dps_uart_rx_os.sv
// 16x-oversampling UART receiver, 8 data bits, majority vote at ticks 7/8/9.
// Define DPS_UART_RX_PARITY_EN to insert a parity bit between data and stop.
module dps_uart_rx_os #(
    parameter int OSR   = dps_uart_pkg::OSR,
    parameter int DIV_W = 16
) (
    input  logic             iCLOCK,
    input  logic             inRESET,
    input  logic [DIV_W-1:0] iBAUD_DIV,
    input  logic             iRX_EN,
    input  logic             iPARITY_ODD,
    input  logic             iUART_RXD,
    output logic             oRX_VALID,
    output logic [7:0]       oRX_DATA,
    output logic             oRX_FRAME_ERR,
    output logic             oRX_BREAK,
    output logic             oRX_PARITY_ERR,
    output logic             oRX_BUSY
);
    import dps_uart_pkg::*;

    logic                   rxdMeta, rxdS;
    logic                   tick, restart;
    rxState_e               state, stateNext;
    logic [$clog2(OSR)-1:0] sampCnt;
    logic [2:0]             bitCnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   smpA, smpB;
    logic                   bitVal, bitDecided, bitEnd;
    logic                   validQ, frameErrQ, breakQ;
    logic [7:0]             rxDataQ;

    // Synchroniser idles high so reset does not look like a start bit.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rxdMeta <= 1'b1;
            rxdS    <= 1'b1;
        end else begin
            rxdMeta <= iUART_RXD;
            rxdS    <= rxdMeta;
        end
    end

    dps_uart_baud_tick #(.DIV_W(DIV_W)) uBaudTick (
        .iCLOCK   (iCLOCK),
        .inRESET  (inRESET),
        .iDIV     (iBAUD_DIV),
        .iRESTART (restart),
        .oTICK    (tick)
    );

    assign bitVal     = majority3(smpA, smpB, rxdS);
    assign bitDecided = tick && (sampCnt == SAMP_C);
    assign bitEnd     = tick && (sampCnt == SAMP_LAST);
    assign restart    = (state == IDLE) && (stateNext == START);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (!iRX_EN) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:      if (tick && !rxdS) stateNext = START;
                START: begin
                    // A high majority in the start bit is a glitch, not a frame.
                    if (bitDecided && bitVal) stateNext = IDLE;
                    else if (bitEnd)          stateNext = DATA;
                end
                DATA: begin
                    if (bitEnd && (bitCnt == LAST_BIT)) begin
`ifdef DPS_UART_RX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end
                end
                PARITY:    if (bitEnd) stateNext = STOP;
                STOP:      if (bitDecided) stateNext = bitVal ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (tick && rxdS) stateNext = IDLE;
                default:   stateNext = IDLE;
            endcase
        end
    end

`ifdef DPS_UART_RX_PARITY_EN
    logic parityBad, parityErrQ;
`else
    logic unusedParityOdd;
    assign unusedParityOdd = iPARITY_ODD;
`endif

    // Flags are single-cycle: cleared every clock, set only with the valid pulse.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            sampCnt    <= '0;
            bitCnt     <= '0;
            shreg      <= '0;
            smpA       <= 1'b1;
            smpB       <= 1'b1;
            validQ     <= 1'b0;
            frameErrQ  <= 1'b0;
            breakQ     <= 1'b0;
            rxDataQ    <= '0;
`ifdef DPS_UART_RX_PARITY_EN
            parityBad  <= 1'b0;
            parityErrQ <= 1'b0;
`endif
        end else begin
            validQ    <= 1'b0;
            frameErrQ <= 1'b0;
            breakQ    <= 1'b0;
`ifdef DPS_UART_RX_PARITY_EN
            parityErrQ <= 1'b0;
`endif
            if (state == IDLE || !iRX_EN) begin
                sampCnt <= '0;
                bitCnt  <= '0;
            end else if (tick) begin
                sampCnt <= sampCnt + 1'b1;
                if (sampCnt == SAMP_A) smpA <= rxdS;
                if (sampCnt == SAMP_B) smpB <= rxdS;
                if (state == DATA && bitDecided) shreg <= {bitVal, shreg[DATA_BITS-1:1]};
                if (state == DATA && bitEnd)     bitCnt <= bitCnt + 1'b1;
`ifdef DPS_UART_RX_PARITY_EN
                if (state == PARITY && bitDecided)
                    parityBad <= ((^shreg) ^ bitVal) != iPARITY_ODD;
`endif
                if (state == STOP && bitDecided) begin
                    rxDataQ   <= shreg;
                    validQ    <= 1'b1;
                    frameErrQ <= !bitVal;
                    breakQ    <= !bitVal && (shreg == '0);
`ifdef DPS_UART_RX_PARITY_EN
                    parityErrQ <= parityBad;
`endif
                end
            end
        end
    end

    assign oRX_VALID     = validQ;
    assign oRX_DATA      = rxDataQ;
    assign oRX_FRAME_ERR = frameErrQ;
    assign oRX_BREAK     = breakQ;
    assign oRX_BUSY      = (state != IDLE);
`ifdef DPS_UART_RX_PARITY_EN
    assign oRX_PARITY_ERR = parityErrQ;
`else
    assign oRX_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dps_uart_rx_os.sv
// Directed bench for dps_uart_rx_os: framing, glitches, break, abort, reset, parity.
module tb_dps_uart_rx_os;

`ifdef DPS_UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int LAT_LO     = 683;
`else
    localparam int FRAME_BITS = 10;
    localparam int LAT_LO     = 619;
`endif
    localparam int BIT_CLKS = 64;
    localparam int NONE     = -10;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       brk;
        logic       pe;
        int         cyc;
    } rxRec_t;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic [15:0] iBAUD_DIV = 16'd3;
    logic        iRX_EN = 1'b0;
    logic        iPARITY_ODD = 1'b0;
    logic        iUART_RXD = 1'b1;
    logic        oRX_VALID;
    logic [7:0]  oRX_DATA;
    logic        oRX_FRAME_ERR, oRX_BREAK, oRX_PARITY_ERR, oRX_BUSY;

    int     testsRun = 0;
    int     testsFailed = 0;
    int     cycle = 0;
    int     flagLeak = 0;
    rxRec_t got[$];
    int     startCycles[$];

    dps_uart_rx_os dut (
        .iCLOCK         (iCLOCK),
        .inRESET        (inRESET),
        .iBAUD_DIV      (iBAUD_DIV),
        .iRX_EN         (iRX_EN),
        .iPARITY_ODD    (iPARITY_ODD),
        .iUART_RXD      (iUART_RXD),
        .oRX_VALID      (oRX_VALID),
        .oRX_DATA       (oRX_DATA),
        .oRX_FRAME_ERR  (oRX_FRAME_ERR),
        .oRX_BREAK      (oRX_BREAK),
        .oRX_PARITY_ERR (oRX_PARITY_ERR),
        .oRX_BUSY       (oRX_BUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    always @(posedge iCLOCK) cycle++;

    // Every valid pulse is captured; status flags outside a pulse are counted.
    always @(negedge iCLOCK) begin
        if (oRX_VALID) begin
            got.push_back('{oRX_DATA, oRX_FRAME_ERR, oRX_BREAK, oRX_PARITY_ERR, cycle});
        end else if (oRX_FRAME_ERR || oRX_BREAK || oRX_PARITY_ERR) begin
            flagLeak++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iCLOCK);
    endtask

    // Drives one frame at 64 clocks/bit; optional glitch, enable drop or reset inside it.
    task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit,
                                 input int glitchBit, input int abortBit, input int resetBit);
        logic frameBits[11];
        frameBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frameBits[i+1] = data[i];
`ifdef DPS_UART_RX_PARITY_EN
        frameBits[9]  = parBit;
        frameBits[10] = stopBit;
`else
        frameBits[9]  = stopBit;
        frameBits[10] = 1'b1;
`endif
        if (abortBit == NONE && resetBit == NONE) startCycles.push_back(cycle);
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int j = 0; j < BIT_CLKS; j++) begin
                if (b == resetBit + 1 && j == 20) begin
                    checkOutput("reset busy before", oRX_BUSY, 1);
                    inRESET   = 1'b0;
                    iUART_RXD = 1'b1;
                    idle(3);
                    checkOutput("reset busy", oRX_BUSY, 0);
                    checkOutput("reset valid", oRX_VALID, 0);
                    checkOutput("reset data", oRX_DATA, 8'h00);
                    checkOutput("reset frame err", oRX_FRAME_ERR, 0);
                    inRESET = 1'b1;
                    return;
                end
                if (b == abortBit + 1 && j == 20) begin
                    checkOutput("abort busy before", oRX_BUSY, 1);
                    iRX_EN = 1'b0;
                    @(negedge iCLOCK);
                    checkOutput("abort busy", oRX_BUSY, 0);
                end
                iUART_RXD = (b == glitchBit + 1 && j >= 36 && j < 40) ? ~frameBits[b] : frameBits[b];
                @(negedge iCLOCK);
            end
        end
        iUART_RXD = 1'b1;
        iRX_EN    = 1'b1;
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] data,
                              input logic fe, input logic brk, input logic pe);
        rxRec_t r;
        int     lat;
        checkOutput({tag, " present"}, (got.size() > 0), 1);
        if (got.size() > 0) begin
            r   = got.pop_front();
            lat = (startCycles.size() > 0) ? r.cyc - startCycles.pop_front() : -1;
            checkOutput({tag, " data"}, r.data, data);
            checkOutput({tag, " frame err"}, r.fe, fe);
            checkOutput({tag, " break"}, r.brk, brk);
            checkOutput({tag, " parity err"}, r.pe, pe);
            checkOutput({tag, " latency"}, (lat >= LAT_LO && lat <= LAT_LO + 3), 1);
        end
    endtask

    initial begin
        int c0;
        idle(5);
        checkOutput("rst valid", oRX_VALID, 0);
        checkOutput("rst data", oRX_DATA, 8'h00);
        checkOutput("rst frame err", oRX_FRAME_ERR, 0);
        checkOutput("rst break", oRX_BREAK, 0);
        checkOutput("rst parity err", oRX_PARITY_ERR, 0);
        checkOutput("rst busy", oRX_BUSY, 0);
        inRESET = 1'b1;
        iRX_EN  = 1'b1;
        idle(100);

        applyStimulus(8'hA5, ^8'hA5, 1'b1, NONE, NONE, NONE);
        checkFrame("basic A5", 8'hA5, 0, 0, 0);
        idle(200);
        checkOutput("basic idle busy", oRX_BUSY, 0);

        applyStimulus(8'h00, ^8'h00, 1'b1, NONE, NONE, NONE);
        applyStimulus(8'hFF, ^8'hFF, 1'b1, NONE, NONE, NONE);
        applyStimulus(8'h3C, ^8'h3C, 1'b1, NONE, NONE, NONE);
        checkFrame("b2b 00", 8'h00, 0, 0, 0);
        checkFrame("b2b FF", 8'hFF, 0, 0, 0);
        checkFrame("b2b 3C", 8'h3C, 0, 0, 0);
        idle(200);

        c0 = cycle;
        iUART_RXD = 1'b0;
        idle(8);
        iUART_RXD = 1'b1;
        idle(4);
        checkOutput("false start busy", oRX_BUSY, 1);
        idle(150);
        checkOutput("false start idle", oRX_BUSY, 0);
        checkOutput("false start frames", got.size(), 0);
        if (cycle - c0 < 150) checkOutput("false start timing", cycle - c0, 162);

        applyStimulus(8'h55, ^8'h55, 1'b1, 3, NONE, NONE);
        checkFrame("glitch 55", 8'h55, 0, 0, 0);
        idle(200);

        applyStimulus(8'h41, ^8'h41, 1'b0, NONE, NONE, NONE);
        checkFrame("stop0 41", 8'h41, 1, 0, 0);
        idle(100);
        checkOutput("stop0 idle busy", oRX_BUSY, 0);

        startCycles.push_back(cycle);
        iUART_RXD = 1'b0;
        idle(30 * BIT_CLKS);
        iUART_RXD = 1'b1;
        idle(200);
        checkFrame("break", 8'h00, 1, 1, 0);
        checkOutput("break single", got.size(), 0);
        applyStimulus(8'h5A, ^8'h5A, 1'b1, NONE, NONE, NONE);
        checkFrame("after break 5A", 8'h5A, 0, 0, 0);
        idle(200);

        applyStimulus(8'h96, ^8'h96, 1'b1, NONE, 4, NONE);
        idle(200);
        checkOutput("abort frames", got.size(), 0);
        checkOutput("abort data kept", oRX_DATA, 8'h5A);

`ifdef DPS_UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1, NONE, NONE, NONE);
        checkFrame("parity ok", 8'h07, 0, 0, 0);
        applyStimulus(8'h07, 1'b0, 1'b1, NONE, NONE, NONE);
        checkFrame("parity bad", 8'h07, 0, 0, 1);
        iPARITY_ODD = 1'b1;
        applyStimulus(8'h07, 1'b0, 1'b1, NONE, NONE, NONE);
        checkFrame("parity odd ok", 8'h07, 0, 0, 0);
        iPARITY_ODD = 1'b0;
        idle(200);
`else
        iPARITY_ODD = 1'b1;
        applyStimulus(8'h07, 1'b1, 1'b1, NONE, NONE, NONE);
        checkFrame("no parity 07", 8'h07, 0, 0, 0);
        iPARITY_ODD = 1'b0;
        idle(200);
`endif

        applyStimulus(8'hC3, ^8'hC3, 1'b1, NONE, NONE, 3);
        idle(300);
        checkOutput("reset frames", got.size(), 0);
        checkOutput("reset idle busy", oRX_BUSY, 0);
        checkOutput("reset data held", oRX_DATA, 8'h00);

        checkOutput("flags outside valid", flagLeak, 0);
        checkOutput("extra frames", got.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
